// File: rtl/motor_pwm_decoder.sv
// PWM / direction feedback decoder: per-period high time, period length, direction code and stall flagging.
// Optional input synchronizers are enabled by defining PWM_DEC_SYNC_EN.
`timescale 1ns/1ps

module motor_pwm_decoder #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  input  logic             dir_left_in,
  input  logic             dir_right_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic [1:0]       dir_code,
  output logic             stalled,
  output logic             stall_level,
  output logic             dir_fault
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_e;

  logic p;
  logic dir_l;
  logic dir_r;

`ifdef PWM_DEC_SYNC_EN
  logic [1:0] pwm_sync_d,   pwm_sync_q;
  logic [1:0] left_sync_d,  left_sync_q;
  logic [1:0] right_sync_d, right_sync_q;

  always_comb begin
    pwm_sync_d   = {pwm_sync_q[0],   pwm_in};
    left_sync_d  = {left_sync_q[0],  dir_left_in};
    right_sync_d = {right_sync_q[0], dir_right_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_sync_q   <= '0;
      left_sync_q  <= '0;
      right_sync_q <= '0;
    end else begin
      pwm_sync_q   <= pwm_sync_d;
      left_sync_q  <= left_sync_d;
      right_sync_q <= right_sync_d;
    end
  end

  assign p     = pwm_sync_q[1];
  assign dir_l = left_sync_q[1];
  assign dir_r = right_sync_q[1];
`else
  assign p     = pwm_in;
  assign dir_l = dir_left_in;
  assign dir_r = dir_right_in;
`endif

  state_e           state_d,       state_q;
  logic             pwm_d,         pwm_q;
  logic [CNT_W-1:0] period_run_d,  period_run_q;
  logic [CNT_W-1:0] high_run_d,    high_run_q;
  logic             meas_valid_d,  meas_valid_q;
  logic [CNT_W-1:0] period_cnt_d,  period_cnt_q;
  logic [CNT_W-1:0] high_cnt_d,    high_cnt_q;
  logic [1:0]       dir_code_d,    dir_code_q;
  logic             stalled_d,     stalled_q;
  logic             stall_level_d, stall_level_q;
  logic             dir_fault_d,   dir_fault_q;

  logic             rise;
  logic             timeout;
  logic [CNT_W-1:0] period_inc;
  logic [CNT_W-1:0] high_inc;

  always_comb begin
    rise       = p & ~pwm_q;
    timeout    = (period_run_q == TMO) && !rise && !stalled_q;
    period_inc = (period_run_q == TMO) ? period_run_q : period_run_q + ONE;
    high_inc   = (high_run_q   == TMO) ? high_run_q   : high_run_q   + ONE;

    state_d       = state_q;
    pwm_d         = p;
    period_run_d  = period_run_q;
    high_run_d    = high_run_q;
    meas_valid_d  = 1'b0;
    period_cnt_d  = period_cnt_q;
    high_cnt_d    = high_cnt_q;
    dir_code_d    = dir_code_q;
    stalled_d     = stalled_q;
    stall_level_d = stall_level_q;
    dir_fault_d   = dir_l & dir_r;

    case (state_q)
      IDLE: begin
        // First rise only arms the measurement; the period before it is unknown.
        if (rise) begin
          period_run_d = ONE;
          high_run_d   = ONE;
          stalled_d    = 1'b0;
          state_d      = HIGH;
        end else begin
          period_run_d = period_inc;
        end
      end
      HIGH: begin
        period_run_d = period_inc;
        if (p) begin
          high_run_d = high_inc;
        end else begin
          state_d = LOW;
        end
      end
      LOW: begin
        if (rise) begin
          period_cnt_d = period_run_q;
          high_cnt_d   = high_run_q;
          dir_code_d   = {dir_l, dir_r};
          meas_valid_d = 1'b1;
          period_run_d = ONE;
          high_run_d   = ONE;
          state_d      = HIGH;
        end else begin
          period_run_d = period_inc;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Stall overrides the state-local update; a rise on the limit cycle is a capture instead.
    if (timeout) begin
      period_cnt_d  = '0;
      high_cnt_d    = '0;
      stall_level_d = p;
      stalled_d     = 1'b1;
      meas_valid_d  = 1'b1;
      state_d       = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pwm_q         <= 1'b0;
      period_run_q  <= '0;
      high_run_q    <= '0;
      meas_valid_q  <= 1'b0;
      period_cnt_q  <= '0;
      high_cnt_q    <= '0;
      dir_code_q    <= '0;
      stalled_q     <= 1'b0;
      stall_level_q <= 1'b0;
      dir_fault_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pwm_q         <= pwm_d;
      period_run_q  <= period_run_d;
      high_run_q    <= high_run_d;
      meas_valid_q  <= meas_valid_d;
      period_cnt_q  <= period_cnt_d;
      high_cnt_q    <= high_cnt_d;
      dir_code_q    <= dir_code_d;
      stalled_q     <= stalled_d;
      stall_level_q <= stall_level_d;
      dir_fault_q   <= dir_fault_d;
    end
  end

  assign meas_valid  = meas_valid_q;
  assign period_cnt  = period_cnt_q;
  assign high_cnt    = high_cnt_q;
  assign dir_code    = dir_code_q;
  assign stalled     = stalled_q;
  assign stall_level = stall_level_q;
  assign dir_fault   = dir_fault_q;

endmodule

// File: tb/tb_motor_pwm_decoder.sv
// Scoreboard bench for motor_pwm_decoder (TIMEOUT=64); expected strobes are queued as PWM stimulus is driven.
`timescale 1ns/1ps

module tb_motor_pwm_decoder;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned TMO   = 64;
`ifdef PWM_DEC_SYNC_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             pwm_in;
  logic             dir_left_in;
  logic             dir_right_in;
  logic             meas_valid;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic [1:0]       dir_code;
  logic             stalled;
  logic             stall_level;
  logic             dir_fault;

  motor_pwm_decoder #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pwm_in      (pwm_in),
    .dir_left_in (dir_left_in),
    .dir_right_in(dir_right_in),
    .meas_valid  (meas_valid),
    .period_cnt  (period_cnt),
    .high_cnt    (high_cnt),
    .dir_code    (dir_code),
    .stalled     (stalled),
    .stall_level (stall_level),
    .dir_fault   (dir_fault)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    int unsigned per;
    int unsigned hi;
    logic [1:0]  dir;
    logic        st;
    logic        lvl;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [1:0]  last_dir;
  logic        last_lvl;
  int unsigned rc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive(input logic p, input logic l, input logic r);
    @(negedge clk);
    pwm_in       = p;
    dir_left_in  = l;
    dir_right_in = r;
  endtask

  task automatic hold(input logic p, input logic l, input logic r, input int n);
    for (int i = 0; i < n; i++) drive(p, l, r);
  endtask

  task automatic push(input int unsigned c, input int unsigned per, input int unsigned hi,
                      input logic [1:0] d, input logic st, input logic lvl);
    exp_t x;
    x.cyc = c; x.per = per; x.hi = hi; x.dir = d; x.st = st; x.lvl = lvl;
    sb.push_back(x);
  endtask

  // One PWM period starting with its rise; cap queues the capture that rise is due to produce.
  task automatic pulse(input int hi, input int per, input logic l, input logic r,
                       input bit cap, input int unsigned ep, input int unsigned eh);
    drive(1'b1, l, r);
    rc = cyc;
    if (cap) begin
      push(cyc + 1 + LAT, ep, eh, {l, r}, 1'b0, last_lvl);
      last_dir = {l, r};
    end
    for (int i = 1; i < per; i++) drive(logic'(i < hi), l, r);
  endtask

  always @(negedge clk) begin
    if (meas_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", meas_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        check("strobe_cycle", cyc, e.cyc);
        check("period_cnt", period_cnt, e.per);
        check("high_cnt", high_cnt, e.hi);
        check("dir_code", dir_code, e.dir);
        check("stalled", stalled, e.st);
        check("stall_level", stall_level, e.lvl);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_meas_valid"}, meas_valid, 1'b0);
    check({tag, "_period_cnt"}, period_cnt, 0);
    check({tag, "_high_cnt"}, high_cnt, 0);
    check({tag, "_dir_code"}, dir_code, 2'b00);
    check({tag, "_stalled"}, stalled, 1'b0);
    check({tag, "_stall_level"}, stall_level, 1'b0);
    check({tag, "_dir_fault"}, dir_fault, 1'b0);
  endtask

  initial begin
    rst = 1'b1; pwm_in = 1'b0; dir_left_in = 1'b0; dir_right_in = 1'b0;
    last_dir = 2'b00; last_lvl = 1'b0;

    // Reset with pwm toggling
    for (int i = 0; i < 3; i++) drive(logic'(i % 2 == 0), 1'b0, 1'b0);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0; pwm_in = 1'b0;

    // Steady PWM 10/3, left direction; first rise only arms
    pulse(3, 10, 1'b1, 1'b0, 0, 0, 0);
    for (int k = 0; k < 5; k++) pulse(3, 10, 1'b1, 1'b0, 1, 10, 3);
    check("dir_fault_clear", dir_fault, 1'b0);

    // Held low: one stall strobe 64 cycles after the last rise, then silence
    push(rc + 1 + TMO + LAT, 0, 0, last_dir, 1'b1, 1'b0);
    last_lvl = 1'b0;
    hold(1'b0, 1'b1, 1'b0, 90);
    check("stalled_held", stalled, 1'b1);
    pulse(3, 10, 1'b1, 1'b0, 0, 0, 0);
    check("stall_cleared", stalled, 1'b0);
    pulse(3, 10, 1'b1, 1'b0, 1, 10, 3);

    // One-cycle pulses at maximum strobe rate
    pulse(1, 2, 1'b1, 1'b0, 1, 10, 3);
    pulse(1, 2, 1'b1, 1'b0, 1, 2, 1);
    pulse(1, 5, 1'b1, 1'b0, 1, 2, 1);
    pulse(3, 10, 1'b1, 1'b0, 1, 5, 1);

    // Both direction lines high
    pulse(4, 10, 1'b1, 1'b1, 1, 10, 3);
    check("dir_fault_set", dir_fault, 1'b1);
    pulse(3, 10, 1'b0, 1'b1, 1, 10, 4);
    check("dir_fault_drop", dir_fault, 1'b0);

    // Stuck high: the rise captures, then a stall with level 1
    drive(1'b1, 1'b0, 1'b1);
    rc = cyc;
    push(cyc + 1 + LAT, 10, 3, 2'b01, 1'b0, last_lvl);
    last_dir = 2'b01;
    push(rc + 1 + TMO + LAT, 0, 0, last_dir, 1'b1, 1'b1);
    last_lvl = 1'b1;
    hold(1'b1, 1'b0, 1'b1, 79);
    hold(1'b0, 1'b0, 1'b1, 5);
    check("stuck_high_stalled", stalled, 1'b1);
    check("stuck_high_level", stall_level, 1'b1);

    // dir_fault latency
    drive(1'b0, 1'b1, 1'b1);
    check("dir_fault_early", dir_fault, 1'b0);
    for (int i = 0; i < int'(LAT); i++) begin
      drive(1'b0, 1'b1, 1'b1);
      check("dir_fault_early", dir_fault, 1'b0);
    end
    drive(1'b0, 1'b1, 1'b1);
    check("dir_fault_latency", dir_fault, 1'b1);
    hold(1'b0, 1'b0, 1'b1, 4);

    // Rise exactly TIMEOUT cycles after the previous one is a capture
    pulse(5, 64, 1'b0, 1'b1, 0, 0, 0);
    pulse(5, 64, 1'b0, 1'b1, 1, 64, 5);
    pulse(3, 10, 1'b0, 1'b1, 1, 64, 5);
    pulse(3, 10, 1'b0, 1'b1, 1, 10, 3);

    // Reset mid-period discards the partial measurement
    drive(1'b1, 1'b1, 1'b0);
    push(cyc + 1 + LAT, 10, 3, 2'b10, 1'b0, last_lvl);
    hold(1'b1, 1'b1, 1'b0, 1);
    hold(1'b0, 1'b1, 1'b0, 2);
    @(negedge clk);
    rst = 1'b1; pwm_in = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    last_dir = 2'b00; last_lvl = 1'b0;
    pulse(3, 10, 1'b1, 1'b0, 0, 0, 0);
    pulse(6, 10, 1'b1, 1'b0, 1, 10, 3);
    pulse(3, 10, 1'b1, 1'b0, 1, 10, 6);
    hold(1'b0, 1'b1, 1'b0, 8);

    check("pending_expectations", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
    $fatal(1);
  end

endmodule

// File: doc/motor_pwm_decoder.md
# motor_pwm_decoder

Measures the PWM and direction outputs of the motor driver stage and reports them as digital counts. Per PWM period it reports the high time, the period length and the sampled direction code. It also flags stalled PWM (stuck high or low) and illegal direction combinations. It sits on the driver's output side as a feedback/monitor block, so the CNN accelerator's control loop and the bench can confirm the commanded drive.

## Interface
Parameters:
- CNT_W, 16, width of all cycle counters and count outputs
- TIMEOUT, 16'hFFFF, longest measurable period in clk cycles; must be ≥ 2 and ≤ 2^CNT_W−1

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- pwm_in  in  1  PWM from the motor driver
- dir_left_in  in  1  left direction line
- dir_right_in  in  1  right direction line
- meas_valid  out  1  one-cycle strobe; count/direction outputs updated in the same cycle
- period_cnt  out  CNT_W  cycles between the last two rising edges (0 on stall)
- high_cnt  out  CNT_W  cycles pwm was sampled high in that period (0 on stall)
- dir_code  out  2  {dir_left_in, dir_right_in} sampled at the capture edge
- stalled  out  1  no rising edge for TIMEOUT cycles
- stall_level  out  1  pwm level when the stall was declared
- dir_fault  out  1  dir_left_in & dir_right_in, registered

## Operation
- p = pwm sample (pwm_in, or the synchronizer output under the macro); pwm_q = p delayed by one cycle; rise = p & ~pwm_q.
- Internal counters: period_run and high_run, both CNT_W wide and saturating at TIMEOUT.
- FSM states: IDLE, HIGH, LOW.
- IDLE, on rise: period_run←1, high_run←1, clear stalled, go to HIGH. No measurement is produced, because the period is incomplete.
- IDLE, no rise: period_run increments, saturating.
- HIGH: period_run++. If p=1, high_run++. If p=0, go to LOW.
- LOW: period_run++. On rise: capture, then period_run←1, high_run←1, go to HIGH.
- Capture: period_cnt←period_run, high_cnt←high_run, dir_code←{dir_left_in,dir_right_in}, meas_valid←1.
- Timeout (any state, when period_run==TIMEOUT, no rise this cycle and stalled=0): period_cnt←0, high_cnt←0, stall_level←p, stalled←1, meas_valid←1, go to IDLE.
- A rise in the same cycle that period_run==TIMEOUT is a normal capture with period TIMEOUT.
- After a stall, no further strobes occur until two rising edges have been seen. The first rise clears stalled; the second produces a capture.
- Pulses of one cycle high are legal and give high_cnt=1.
- dir_fault is a level with one cycle of latency and is independent of the FSM.
- Reset values: all outputs 0, FSM in IDLE, counters 0, pwm_q=0.
- rst has priority over every event. Reset mid-period discards the partial measurement.

## Timing
- Capture and timeout outputs register on the same edge where the condition is evaluated. meas_valid is high for exactly one cycle.
- period_cnt, high_cnt, dir_code, stall_level and stalled hold their values between strobes.
- Latency from pwm_in to rise detection is 0 cycles without the macro and 2 cycles with it. Counts are unaffected.
- Maximum strobe rate is one per 2 cycles (PWM period 2).

## Configuration
- PWM_DEC_SYNC_EN defined: pwm_in, dir_left_in and dir_right_in each pass through a 2-flop synchronizer (reset to 0) before any logic. All detection and capture happens 2 cycles later.
- PWM_DEC_SYNC_EN not defined: inputs are used directly as same-domain signals.

## Test plan
- Reset: rst high 3 cycles with pwm toggling -> all outputs 0; the first rise after release produces no meas_valid.
- Steady PWM, period 10 / high 3, dir_left_in=1, dir_right_in=0 -> from the 2nd rise, meas_valid every 10 cycles with period_cnt=10, high_cnt=3, dir_code=2'b10.
- TIMEOUT=64, pwm held low after a run -> 64 cycles after the last rise, one strobe with period_cnt=0, high_cnt=0, stalled=1, stall_level=0, then no further strobes. The next rise clears stalled; the following rise captures.
- TIMEOUT=64, pwm stuck high -> stall strobe with stall_level=1. A rise exactly 64 cycles after the previous rise instead gives period_cnt=64 with no stall.
- Both direction lines high -> dir_fault=1 one cycle later; the next capture shows dir_code=2'b11.
- rst pulsed mid-period, then compiled with PWM_DEC_SYNC_EN -> partial period is discarded; with the macro, strobes lag by 2 cycles and counts are identical.
